// File: rtl/prbs15_err_checker.sv
// PRBS15 (x^15+x^14+1, XNOR feedback) serial error checker: hunt, verify, flywheel-locked error counting.
// Optional 32-bit checked-bit counter enabled by defining PRBS_CHK_BITCNT_EN.
module prbs15_err_checker #(
    parameter int LOCK_THRESH = 16,
    parameter int WIN_LEN     = 64,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_vld,
    input  logic             din,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sat
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [31:0]      bit_cnt
`endif
);

    localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
    localparam int WIN_W   = $clog2(WIN_LEN);
    localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_THRESH - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WIN_LEN - 1);
    localparam logic [WERR_W-1:0]  WERR_LOSS  = WERR_W'(LOSS_THRESH);

    logic [1:0]         state_q, state_d;
    logic [14:0]        sr_q, sr_d;
    logic [3:0]         fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [WERR_W-1:0]  werr_q, werr_d;
    logic               err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               err_sat_q, err_sat_d;
    logic               pred;
    logic               mismatch;
    logic [WERR_W-1:0]  werr_nxt;
`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0]        bit_cnt_q, bit_cnt_d;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign pred     = sr_q[14] ~^ sr_q[13];
    assign mismatch = din ^ pred;
    assign werr_nxt = werr_q + WERR_W'(mismatch);

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_d       = win_q;
        werr_d      = werr_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        err_sat_d   = err_sat_q;
`ifdef PRBS_CHK_BITCNT_EN
        bit_cnt_d   = bit_cnt_q;
`endif
        if (bit_vld) begin
            case (state_q)
                HUNT: begin
                    sr_d = {sr_q[13:0], din};
                    if (fill_q == 4'd14) begin
                        state_d = VERIFY;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + 4'd1;
                    end
                end
                VERIFY: begin
                    // Keep shifting received bits so a bad seed self-corrects without a refill.
                    sr_d = {sr_q[13:0], din};
                    if (mismatch) begin
                        match_d = '0;
                    end else if (match_q == MATCH_LAST) begin
                        state_d = LOCKED;
                        match_d = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end
                LOCKED: begin
                    // Flywheel on the prediction so received errors never poison the reference.
                    sr_d = {sr_q[13:0], pred};
`ifdef PRBS_CHK_BITCNT_EN
                    bit_cnt_d = bit_cnt_q + 32'd1;
`endif
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        err_cnt_d   = sat_inc(err_cnt_q);
                        err_sat_d   = err_sat_q | (&err_cnt_d);
                    end
                    if (werr_nxt == WERR_LOSS) begin
                        state_d = HUNT;
                        fill_d  = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else if (win_q == WIN_LAST) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d  = win_q + 1'b1;
                        werr_d = werr_nxt;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        if (clr) begin
            err_cnt_d = '0;
            err_sat_d = 1'b0;
`ifdef PRBS_CHK_BITCNT_EN
            bit_cnt_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            err_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            err_sat_q   <= err_sat_d;
        end
    end

`ifdef PRBS_CHK_BITCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bit_cnt = bit_cnt_q;
`endif

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign err_sat   = err_sat_q;

endmodule

// File: tb/tb_prbs15_err_checker.sv
// Directed bench for prbs15_err_checker: lock, error injection, loss/relock, saturation, clr, gapped valid, reset.
module tb_prbs15_err_checker;

    logic       clk;
    logic       rst_n;
    logic       bit_vld;
    logic       din;
    logic       clr;
    logic       locked, err_pulse, err_sat;
    logic [7:0] err_cnt;
    logic       locked4, err_pulse4, err_sat4;
    logic [3:0] err_cnt4;
`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0] bit_cnt, bit_cnt4;
`endif

    logic [14:0] hist;
    int          n_vec;
    int          n_miss;
    int          pulses;

    prbs15_err_checker #(.CNT_W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_vld   (bit_vld),
        .din       (din),
        .clr       (clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .err_sat   (err_sat)
`ifdef PRBS_CHK_BITCNT_EN
        ,
        .bit_cnt   (bit_cnt)
`endif
    );

    prbs15_err_checker #(.CNT_W(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_vld   (bit_vld),
        .din       (din),
        .clr       (clr),
        .locked    (locked4),
        .err_pulse (err_pulse4),
        .err_cnt   (err_cnt4),
        .err_sat   (err_sat4)
`ifdef PRBS_CHK_BITCNT_EN
        ,
        .bit_cnt   (bit_cnt4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // b[n] = b[n-15] XNOR b[n-14], history starts all-zero.
    task automatic gen_bit(output logic b);
        b    = ~(hist[14] ^ hist[13]);
        hist = {hist[13:0], b};
    endtask

    task automatic send(input logic b, input logic c);
        din     = b;
        bit_vld = 1'b1;
        clr     = c;
        @(posedge clk);
        #1;
        bit_vld = 1'b0;
        clr     = 1'b0;
        if (err_pulse) pulses++;
    endtask

    task automatic send_prbs(input logic inv, input logic c);
        logic b;
        gen_bit(b);
        send(b ^ inv, c);
    endtask

    task automatic idle(input logic c);
        bit_vld = 1'b0;
        din     = 1'b0;
        clr     = c;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_miss  = 0;
        pulses  = 0;
        hist    = '0;
        rst_n   = 1'b0;
        bit_vld = 1'b0;
        din     = 1'b0;
        clr     = 1'b0;
        #12;
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_err_pulse", 32'(err_pulse), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_err_sat", 32'(err_sat), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Scenario 1: clean stream from zero seed, lock after 15 + 16 bits
        for (int i = 1; i <= 200; i++) begin
            send_prbs(1'b0, 1'b0);
            if (i == 30) chk("s1_unlocked_30", 32'(locked), 32'd0);
            if (i == 31) chk("s1_locked_31", 32'(locked), 32'd1);
        end
        chk("s1_locked_end", 32'(locked), 32'd1);
        chk("s1_err_cnt", 32'(err_cnt), 32'd0);
        chk("s1_pulses", 32'(pulses), 32'd0);

        // Scenario 2: two isolated inverted bits
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            send_prbs(i == 20 || i == 60, 1'b0);
            if (i == 20) chk("s2_pulse_first", 32'(err_pulse), 32'd1);
            if (i == 21) chk("s2_pulse_drop", 32'(err_pulse), 32'd0);
        end
        chk("s2_pulses", 32'(pulses), 32'd2);
        chk("s2_err_cnt", 32'(err_cnt), 32'd2);
        chk("s2_err_cnt4", 32'(err_cnt4), 32'd2);
        chk("s2_locked", 32'(locked), 32'd1);

        // Scenario 3: corrupted stream forces loss on the 8th error, clean stream relocks in 31 bits
        for (int i = 1; i <= 8; i++) begin
            send_prbs(1'b1, 1'b0);
            if (i == 7) chk("s3_locked_7", 32'(locked), 32'd1);
        end
        chk("s3_lost_8", 32'(locked), 32'd0);
        chk("s3_err_cnt", 32'(err_cnt), 32'd10);
        for (int i = 1; i <= 31; i++) begin
            send_prbs(1'b0, 1'b0);
            if (i == 30) chk("s3_unlocked_30", 32'(locked), 32'd0);
        end
        chk("s3_relocked", 32'(locked), 32'd1);
        chk("s3_err_cnt_kept", 32'(err_cnt), 32'd10);

        // Scenario 4: 20 errors spaced 10 bits apart saturate the 4-bit counter without loss
        idle(1'b1);
        chk("s4_clr_cnt4", 32'(err_cnt4), 32'd0);
        pulses = 0;
        for (int e = 0; e < 20; e++) begin
            for (int k = 0; k < 10; k++) send_prbs(k == 9, 1'b0);
        end
        chk("s4_pulses", 32'(pulses), 32'd20);
        chk("s4_err_cnt4", 32'(err_cnt4), 32'd15);
        chk("s4_err_sat4", 32'(err_sat4), 32'd1);
        chk("s4_err_cnt8", 32'(err_cnt), 32'd20);
        chk("s4_err_sat8", 32'(err_sat), 32'd0);
        chk("s4_locked", 32'(locked), 32'd1);
        idle(1'b1);
        chk("s4_clr_cnt4_b", 32'(err_cnt4), 32'd0);
        chk("s4_clr_sat4", 32'(err_sat4), 32'd0);
        chk("s4_clr_locked", 32'(locked), 32'd1);

        // clr coinciding with an error: counter stays 0, pulse still fires
        send_prbs(1'b1, 1'b1);
        chk("clr_err_pulse", 32'(err_pulse), 32'd1);
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);
        send_prbs(1'b1, 1'b0);
        chk("err_after_clr_cnt", 32'(err_cnt), 32'd1);
        idle(1'b0);
        chk("idle_pulse_low", 32'(err_pulse), 32'd0);
        chk("idle_cnt_hold", 32'(err_cnt), 32'd1);

        // Scenario 5: gapped valid, same lock point in valid bits
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        hist  = '0;
        @(posedge clk);
        #1;
        chk("s5_reset_cnt", 32'(err_cnt), 32'd0);
        for (int i = 1; i <= 31; i++) begin
            send_prbs(1'b0, 1'b0);
            idle(1'b0);
            if (i == 30) chk("s5_unlocked_30", 32'(locked), 32'd0);
        end
        chk("s5_locked_31", 32'(locked), 32'd1);
        send_prbs(1'b1, 1'b0);
        chk("s5_err_pulse", 32'(err_pulse), 32'd1);
        chk("s5_err_cnt", 32'(err_cnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5_async_locked", 32'(locked), 32'd0);
        chk("s5_async_pulse", 32'(err_pulse), 32'd0);
        chk("s5_async_cnt", 32'(err_cnt), 32'd0);
        #4;
        rst_n = 1'b1;
        hist  = '0;
        @(posedge clk);
        #1;

        // Scenario 6: relock, then count checked bits when the counter is built in
        for (int i = 1; i <= 31; i++) send_prbs(1'b0, 1'b0);
        chk("s6_locked", 32'(locked), 32'd1);
`ifdef PRBS_CHK_BITCNT_EN
        chk("s6_bit_cnt_start", bit_cnt, 32'd0);
        for (int i = 0; i < 100; i++) send_prbs(1'b0, 1'b0);
        chk("s6_bit_cnt_100", bit_cnt, 32'd100);
        idle(1'b1);
        chk("s6_bit_cnt_clr", bit_cnt, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
